// File: rtl/button_bank.sv
// button_bank: multi-channel button front end (2-flop sync, debounce, press/release edges, toggle, long press).
// Latency: a clean pin edge reaches button_level and its pulse NR_OF_DEBOUNCE_CLKS_P+2 clocks later; all outputs registered.
// Backpressure: none; pulses last one clock and must be consumed every cycle.
// Optional build macro BUTTON_BANK_AUTO_REPEAT_EN adds auto-repeat press pulses after a long press.
module button_bank #(
  parameter int    NR_OF_BUTTONS_P       = 4,
  parameter int    NR_OF_DEBOUNCE_CLKS_P = 1000000,
  parameter string CONNECTION_TYPE_P     = "OPEN",
  parameter int    LONG_PRESS_CLKS_P     = 100000000,
  parameter int    REPEAT_CLKS_P         = 25000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_OF_BUTTONS_P-1:0] button_in_pin,
  input  logic [NR_OF_BUTTONS_P-1:0] button_enable,
  output logic [NR_OF_BUTTONS_P-1:0] button_level,
  output logic [NR_OF_BUTTONS_P-1:0] button_press,
  output logic [NR_OF_BUTTONS_P-1:0] button_release,
  output logic [NR_OF_BUTTONS_P-1:0] button_press_toggle,
  output logic [NR_OF_BUTTONS_P-1:0] button_long_press,
  output logic                       button_any_press
);

  // Pins idle low for OPEN wiring, idle high for CLOSED wiring.
  localparam logic INV_C = (CONNECTION_TYPE_P == "CLOSED");

  localparam int DW = $clog2(NR_OF_DEBOUNCE_CLKS_P + 1);
  localparam int HW = $clog2(LONG_PRESS_CLKS_P + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(NR_OF_DEBOUNCE_CLKS_P - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CLKS_P);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CLKS_P - 1);

  // Elaboration-time parameter sanity checks.
  if (NR_OF_BUTTONS_P < 1 || NR_OF_BUTTONS_P > 32) begin : g_bad_count
    $error("button_bank: NR_OF_BUTTONS_P out of range");
  end
  if (NR_OF_DEBOUNCE_CLKS_P < 2 || LONG_PRESS_CLKS_P <= NR_OF_DEBOUNCE_CLKS_P) begin : g_bad_timing
    $error("button_bank: debounce/long-press lengths inconsistent");
  end
  if (REPEAT_CLKS_P < 2) begin : g_bad_repeat
    $error("button_bank: REPEAT_CLKS_P too small");
  end

  logic [NR_OF_BUTTONS_P-1:0] press_nxt;

  for (genvar i = 0; i < NR_OF_BUTTONS_P; i++) begin : g_ch
    logic          sync1, sync2;
    logic          sample;
    logic          level_q;
    logic          flip;
    logic          rep_fire;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          press_q, release_q, toggle_q, long_q;

    assign sample = sync2 ^ INV_C;
    // Debounce terminal count: the level inverts on this edge.
    assign flip   = (sample != level_q) && (deb_cnt == DEB_LAST);

`ifdef BUTTON_BANK_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CLKS_P + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CLKS_P - 1);
    logic [RW-1:0] rep_cnt;

    // Repeat fires only while the long-press hold is saturated and no release is being accepted.
    assign rep_fire = level_q && !flip && (hold_cnt == HOLD_MAX) && (rep_cnt == REP_LAST);

    // Repeat period counter runs only after the long press has been reached.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 rep_cnt <= '0;
      else if (!level_q || hold_cnt != HOLD_MAX || rep_fire) rep_cnt <= '0;
      else                                        rep_cnt <= rep_cnt + 1'b1;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign press_nxt[i] = button_enable[i] && ((flip && !level_q) || rep_fire);

    // Two-flop synchroniser, reset to the released pin level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= INV_C;
        sync2 <= INV_C;
      end else begin
        sync1 <= button_in_pin[i];
        sync2 <= sync1;
      end
    end

    // Debounce: count consecutive mismatching samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt <= '0;
        level_q <= 1'b0;
      end else if (sample == level_q) begin
        deb_cnt <= '0;
      end else if (flip) begin
        deb_cnt <= '0;
        level_q <= ~level_q;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end

    // Hold counter: saturating while pressed, cleared when released; independent of enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    hold_cnt <= '0;
      else if (!level_q)             hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
    end

    // Registered, enable-gated event outputs and press toggle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        press_q   <= press_nxt[i];
        release_q <= button_enable[i] && flip && level_q;
        long_q    <= button_enable[i] && level_q && (hold_cnt == HOLD_LAST);
        toggle_q  <= toggle_q ^ press_nxt[i];
      end
    end

    assign button_level[i]        = level_q;
    assign button_press[i]        = press_q;
    assign button_release[i]      = release_q;
    assign button_long_press[i]   = long_q;
    assign button_press_toggle[i] = toggle_q;
  end

  // Aggregate press flag, registered alongside the per-channel pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) button_any_press <= 1'b0;
    else        button_any_press <= |press_nxt;
  end

endmodule
